// File: rtl/aidc_lite_stream_buffer.sv
// aidc_lite_stream_buffer
//   Synchronous show-ahead FIFO with valid/ready handshakes on both sides.
//   Sits between AIDC Lite compressor/decompressor stages. Flow control
//   replaces explicit addressing.
//
// Optional feature macro: AIDC_LITE_BUF_FLUSH_EN (adds flush_i)
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   flush_i    in   synchronous flush to empty (only with AIDC_LITE_BUF_FLUSH_EN)
//   wvalid_i   in   producer has data
//   wready_o   out  buffer can accept (count != DEPTH)
//   wdata_i    in   write payload
//   rvalid_o   out  head entry available (count != 0)
//   rready_i   in   consumer takes head
//   rdata_o    out  head entry, show-ahead (don't-care while rvalid_o=0)
//   count_o    out  occupancy 0..DEPTH
//   afull_o    out  count_o >= AFULL_THRESH
module aidc_lite_stream_buffer #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef AIDC_LITE_BUF_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  afull_o
);
  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wptr, r_rptr, r_count;
  logic                  w_push, w_pop;

  // Status decodes only from the count register, so no input reaches an
  // output combinationally (no pass-through when full, no bypass when empty).
  assign wready_o = (r_count != DEPTH_C);
  assign rvalid_o = (r_count != '0);
  assign afull_o  = (r_count >= AFULL_C);
  assign count_o  = r_count;
  assign rdata_o  = r_mem[r_rptr[ADDR_WIDTH-1:0]];

`ifdef AIDC_LITE_BUF_FLUSH_EN
  // Flush wins over any handshake in the same cycle.
  assign w_push = wvalid_i & wready_o & ~flush_i;
  assign w_pop  = rvalid_o & rready_i & ~flush_i;
`else
  assign w_push = wvalid_i & wready_o;
  assign w_pop  = rvalid_o & rready_i;
`endif

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[ADDR_WIDTH-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end
`ifdef AIDC_LITE_BUF_FLUSH_EN
    else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end
`endif
    else begin
      if (w_push) r_wptr <= r_wptr + ONE_C;
      if (w_pop)  r_rptr <= r_rptr + ONE_C;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
    end
  end

  // The wrap bits make the pointer distance unambiguous; it must always
  // agree with the separately kept count register.
  a_ptr_count: assert property (@(posedge clk) disable iff (rst)
    (ADDR_WIDTH+1)'(r_wptr - r_rptr) == r_count);

endmodule

// File: tb/tb_aidc_lite_stream_buffer.sv
module tb_aidc_lite_stream_buffer;
  localparam int DEPTH = 8;
  localparam int THR   = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wvalid = 1'b0, rready = 1'b0, flush = 1'b0;
  logic [63:0] wdata = '0;
  logic        wready, rvalid, afull;
  logic [63:0] rdata;
  logic [3:0]  count;

  int          n_chk = 0, n_pass = 0;
  string       phase = "init";
  logic [63:0] q[$];

  always #5 clk = ~clk;

  aidc_lite_stream_buffer dut (
    .clk      (clk),
    .rst      (rst),
`ifdef AIDC_LITE_BUF_FLUSH_EN
    .flush_i  (flush),
`endif
    .wvalid_i (wvalid),
    .wready_o (wready),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .rready_i (rready),
    .rdata_o  (rdata),
    .count_o  (count),
    .afull_o  (afull)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected status comes from the queue occupancy alone.
  task automatic chk_outs();
    chk({phase, ".count"},  64'(count),  64'(q.size()));
    chk({phase, ".rvalid"}, 64'(rvalid), 64'(q.size() != 0));
    chk({phase, ".wready"}, 64'(wready), 64'(q.size() != DEPTH));
    chk({phase, ".afull"},  64'(afull),  64'(q.size() >= THR));
    if (q.size() != 0) chk({phase, ".rdata"}, rdata, q[0]);
  endtask

  // Called just after a falling edge: drive, check, clock, update model.
  task automatic step(input logic wv, input logic [63:0] wd, input logic rr, input logic fl);
    bit push, pop;
    wvalid = wv; wdata = wd; rready = rr; flush = fl;
    chk_outs();
    push = wv && (q.size() < DEPTH);
    pop  = rr && (q.size() > 0);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(wd);
    end
    @(negedge clk);
  endtask

  initial begin
    // reset asserted: outputs at reset values
    @(negedge clk);
    phase = "rst";
    chk_outs();
    @(negedge clk);
    rst = 1'b0;

    phase = "idle";
    for (int i = 0; i < 10; i++) step(0, '0, 0, 0);

    // fill with 0x11..0x88, then a refused 9th push
    phase = "fill";
    for (int i = 1; i <= 8; i++) step(1, 64'(i * 'h11), 0, 0);
    phase = "full9";
    step(1, 64'h99, 0, 0);
    chk("full9.count_stays", 64'(count), 64'd8);
    phase = "drain";
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
    chk_outs();

    // full with simultaneous push and pop: pop only, then both
    phase = "refill";
    for (int i = 1; i <= 8; i++) step(1, 64'(i * 'h101), 0, 0);
    phase = "fullpp";
    step(1, 64'h99, 1, 0);
    chk("fullpp.count7", 64'(count), 64'd7);
    step(1, 64'h9A, 1, 0);
    chk("fullpp.count7b", 64'(count), 64'd7);
    phase = "drain2";
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0);

    // streaming through pointer wrap
    phase = "stream";
    step(1, 64'h1000, 1, 0);
    for (int i = 1; i <= 40; i++) step(1, 64'h1000 + 64'(i), 1, 0);
    chk("stream.count1", 64'(count), 64'd1);
    step(0, '0, 1, 0);

    // randomized traffic with shifting bias to visit full and empty
    phase = "rand";
    for (int i = 0; i < 400; i++) begin
      int wp, rp;
      wp = (i < 200) ? 75 : 35;
      rp = (i < 200) ? 35 : 75;
      step(($urandom_range(0, 99) < wp), {$urandom, $urandom},
           ($urandom_range(0, 99) < rp), 0);
    end
    phase = "rdrain";
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0);

    // async reset between edges at count=5
    phase = "arst_fill";
    for (int i = 0; i < 5; i++) step(1, 64'h500 + 64'(i), 0, 0);
    chk("arst.pre_count", 64'(count), 64'd5);
    wvalid = 1'b0; rready = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete();
    chk("arst.count_now",  64'(count),  64'd0);
    chk("arst.rvalid_now", 64'(rvalid), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    phase = "arst_after";
    step(1, 64'hA5, 0, 0);
    chk("arst.first_a5", rdata, 64'hA5);
    step(1, 64'hA6, 1, 0);
    step(0, '0, 1, 0);
    chk_outs();

`ifdef AIDC_LITE_BUF_FLUSH_EN
    phase = "flush";
    for (int i = 0; i < 4; i++) step(1, 64'h700 + 64'(i), 0, 0);
    step(1, 64'hDEAD, 1, 1);
    chk("flush.count0",  64'(count),  64'd0);
    chk("flush.rvalid0", 64'(rvalid), 64'd0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    step(1, 64'hBEEF, 0, 0);
    chk("flush.after", rdata, 64'hBEEF);
    step(0, '0, 1, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
